// File: rtl/fetch_stepper.sv
// Fetch/execute sequencer for the 8-bit CPU: owns the fetch-phase bus enables
// and hands the execute phase to the decoder via exec_start/exec_done.
module fetch_stepper #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic             mem_ready,
    input  logic             exec_done,
    output logic             OIAR,
    output logic             IMAR,
    output logic             BUS1,
    output logic             IACC,
    output logic             OMEM,
    output logic             IIR,
    output logic             OACC,
    output logic             IIAR,
    output logic             exec_start,
    output logic             halted,
    output logic [2:0]       step,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        EXEC = 3'd4,
        HALT = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        first_d    = 1'b0;
        cnt_d      = cnt_q;
        OIAR       = 1'b0;
        IMAR       = 1'b0;
        BUS1       = 1'b0;
        IACC       = 1'b0;
        OMEM       = 1'b0;
        IIR        = 1'b0;
        OACC       = 1'b0;
        IIAR       = 1'b0;
        exec_start = 1'b0;
        halted     = 1'b0;
        case (state_q)
            IDLE: if (run) state_d = S1;
            S1: begin
                // IAR onto the bus into MAR, and IAR+1 captured in ACC
                OIAR    = 1'b1;
                IMAR    = 1'b1;
                BUS1    = 1'b1;
                IACC    = 1'b1;
                state_d = S2;
            end
            S2: begin
                OMEM = 1'b1;
                IIR  = mem_ready;
                if (mem_ready) state_d = S3;
            end
            S3: begin
                OACC    = 1'b1;
                IIAR    = 1'b1;
                first_d = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                exec_start = first_q;
                if (exec_done) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (halt_req)  state_d = HALT;
                    else if (run)  state_d = S1;
                    else           state_d = IDLE;
                end
            end
            HALT: halted = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign step        = state_q;
    assign instr_count = cnt_q;

endmodule
